ar_mux_pipe: RTL

AR_MUX_PIPE -- requirements
Module: ar_mux_pipe

---
 rtl/ar_pkg.sv | 18 +
 rtl/ar_skid_buf.sv | 61 ++++++
 rtl/ar_mux_pipe.sv | 75 +++++++
 3 files changed

// File: rtl/ar_pkg.sv
// Shared constants for the arithmetic result multiplexer pipeline:
// select codes, default data width and a select-width sanity helper.
package ar_pkg;

   localparam int AR_WIDTH      = 16;
   localparam int AR_NSRC       = 3;

   localparam int AR_SEL_ZERO   = 0;
   localparam int AR_SEL_LOGIC  = 1;
   localparam int AR_SEL_SHIFT  = 2;
   localparam int AR_SEL_ADDSUB = 3;

   // True when a select of sel_w bits can encode zero plus every channel.
   function automatic bit sel_fits(input int sel_w, input int nsrc);
      return (64'd1 << sel_w) >= 64'(nsrc + 1);
   endfunction

endpackage

// File: rtl/ar_skid_buf.sv
// Two-entry in-order buffer with valid/ready handshakes on both sides.
// Full throughput: a push and a pop in the same cycle keep the occupancy.
module ar_skid_buf #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   logic [DW-1:0] mem_q [2];
   logic [1:0]    count_q, count_d;
   logic          head_q, head_d;
   logic          tail;
   logic          push, pop;

   assign in_ready  = (count_q != 2'd2) && !rst;
   assign out_valid = (count_q != 2'd0);
   assign out_data  = mem_q[head_q];
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready && !rst;
   // The free slot sits one past the head when one entry is held.
   assign tail      = head_q ^ count_q[0];

   // Occupancy and head pointer update from the push/pop pair.
   always_comb begin
      // NOTE: defaults first so every path assigns each output and no latch is inferred.
      count_d = count_q;
      head_d  = head_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01: begin
            count_d = count_q - 2'd1;
            head_d  = ~head_q;
         end
         2'b11:   head_d  = ~head_q;
         default: ;
      endcase
   end

   // State registers and entry storage.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (rst) begin
         count_q <= 2'd0;
         head_q  <= 1'b0;
         // NOTE: only two entries, and the outputs must read zero after reset, so the storage is cleared too.
         for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         if (push) mem_q[tail] <= in_data;
      end
   end

endmodule

// File: rtl/ar_mux_pipe.sv
// Result multiplexer: selects one of NSRC packed sources (or zero) and
// queues the result with its select code and an illegal-select flag.
// Optional macro AR_MUX_FLAGS_EN adds stored out_zero/out_neg flags.
module ar_mux_pipe
   import ar_pkg::*;
#(
   parameter int WIDTH = AR_WIDTH,
   parameter int NSRC  = AR_NSRC,
   parameter int SEL_W = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NSRC*WIDTH-1:0]   src_in,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    out_err,
`ifdef AR_MUX_FLAGS_EN
   output logic                    out_zero,
   output logic                    out_neg,
`endif
   output logic                    out_valid,
   input  logic                    out_ready
);

   if (!sel_fits(SEL_W, NSRC) || NSRC < 1 || NSRC > 15) begin : g_bad_cfg
      $error("ar_mux_pipe: NSRC must be 1..15 and 2**SEL_W >= NSRC+1");
   end

`ifdef AR_MUX_FLAGS_EN
   localparam int FLAG_W = 2;
`else
   localparam int FLAG_W = 0;
`endif
   localparam int DW = FLAG_W + 1 + SEL_W + WIDTH;

   logic [WIDTH-1:0] res_data;
   logic             res_err;
   logic [DW-1:0]    in_pay, out_pay;

   // Select decode: zero code, a legal channel, or illegal (zero + error).
   always_comb begin
      res_data = '0;
      res_err  = 1'b0;
      if (int'(sel) > NSRC) begin
         res_err = 1'b1;
      end else if (int'(sel) != AR_SEL_ZERO) begin
         for (int k = 1; k <= NSRC; k++) begin
            if (int'(sel) == k) res_data = src_in[(k-1)*WIDTH +: WIDTH];
         end
      end
   end

`ifdef AR_MUX_FLAGS_EN
   assign in_pay = {(res_data == '0), res_data[WIDTH-1], res_err, sel, res_data};
   assign {out_zero, out_neg, out_err, out_sel, out_data} = out_pay;
`else
   assign in_pay = {res_err, sel, res_data};
   assign {out_err, out_sel, out_data} = out_pay;
`endif

   ar_skid_buf #(.DW(DW)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_pay),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_pay)
   );

endmodule
